wb_write_arbiter: RTL and testbench

Writer-side companion to the CPU register file: sequences every register write through the regfile's single write port. Merges the in-order pipeline writeback with results from long-latency units (divider, multi-cycle loads) that complete out of band, buffering the latter in a small FIFO. Drives the regfile `WriteEnable`/`WriteAddress`/`WriteData` inputs from registered outputs. Optionally keeps a pending-destination scoreboard so the hazard unit can stall readers of not-yet-written registers.

---
 rtl/wb_write_arbiter_pkg.sv | 19 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/wb_write_arbiter.sv | 119 +++++++++++
 tb/tb_wb_write_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: register geometry,
// the long-result FIFO entry layout and a small address helper.
package wb_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] address;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] address);
    return address == ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding out-of-band long-latency results until the
// write port is free. Push into a full FIFO or pop from an empty one is ignored.
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Sequences pipeline writeback and buffered long-latency results onto the single
// regfile write port. Define WB_SCOREBOARD_EN to build the pending-destination bitmap.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ready,
  input  logic                  PipeWriteEnable,
  input  logic [REG_ADDR_W-1:0] PipeWriteAddress,
  input  logic [REG_DATA_W-1:0] PipeWriteData,
  input  logic                  LongValid,
  output logic                  LongReady,
  input  logic [REG_ADDR_W-1:0] LongAddress,
  input  logic [REG_DATA_W-1:0] LongData,
  input  logic                  IssueValid,
  input  logic [REG_ADDR_W-1:0] IssueAddress,
  input  logic [REG_ADDR_W-1:0] QueryAddress1,
  input  logic [REG_ADDR_W-1:0] QueryAddress2,
  output logic                  Pending1,
  output logic                  Pending2,
  output logic                  WriteEnable,
  output logic [REG_ADDR_W-1:0] WriteAddress,
  output logic [REG_DATA_W-1:0] WriteData
);

  wb_entry_t             long_entry;
  wb_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pipe_valid;
  logic                  long_accept;
  logic                  push;
  logic                  pop;
  logic                  next_enable;
  logic [REG_ADDR_W-1:0] next_address;
  logic [REG_DATA_W-1:0] next_data;

  // Writes to r0 are architecturally void: an r0 pipeline write is idle, an r0 long result is dropped.
  assign pipe_valid  = PipeWriteEnable && !is_zero_reg(PipeWriteAddress);
  assign LongReady   = !fifo_full && !reset && ready;
  assign long_accept = LongValid && LongReady;
  assign push        = long_accept && !is_zero_reg(LongAddress);
  assign pop         = ready && !pipe_valid && !fifo_empty;
  assign long_entry  = '{address: LongAddress, data: LongData};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_entry(long_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-port selection: pipeline first, then FIFO head, else idle; hold while stalled.
  always_comb begin
    next_enable  = WriteEnable;
    next_address = WriteAddress;
    next_data    = WriteData;
    if (ready) begin
      if (pipe_valid) begin
        next_enable  = 1'b1;
        next_address = PipeWriteAddress;
        next_data    = PipeWriteData;
      end else if (pop) begin
        next_enable  = 1'b1;
        next_address = head.address;
        next_data    = head.data;
      end else begin
        next_enable  = 1'b0;
      end
    end else begin
      next_enable = WriteEnable;
    end
  end

  // Registered regfile write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      WriteEnable  <= 1'b0;
      WriteAddress <= ZERO_REG;
      WriteData    <= 32'd0;
    end else begin
      WriteEnable  <= next_enable;
      WriteAddress <= next_address;
      WriteData    <= next_data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [REG_COUNT-1:0] pending;

  // Later non-blocking assignment wins, so an issue on the pop edge keeps the bit set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= {REG_COUNT{1'b0}};
    end else if (ready) begin
      if (pop) pending[head.address] <= 1'b0;
      if (IssueValid && !is_zero_reg(IssueAddress)) pending[IssueAddress] <= 1'b1;
    end
  end

  assign Pending1 = pending[QueryAddress1];
  assign Pending2 = pending[QueryAddress2];
`else
  logic unused_scoreboard;
  assign unused_scoreboard = ^{IssueValid, IssueAddress, QueryAddress1, QueryAddress2};
  assign Pending1 = 1'b0;
  assign Pending2 = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: per-scenario tasks plus a
// write-port scoreboard fed from separate pipeline and long-result queues.
module tb_wb_write_arbiter;

  typedef struct {
    logic [4:0]  address;
    logic [31:0] data;
    int          due;
  } exp_t;

`ifdef WB_SCOREBOARD_EN
  localparam logic PEND_ON = 1'b1;
`else
  localparam logic PEND_ON = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        ready;
  logic        PipeWriteEnable;
  logic [4:0]  PipeWriteAddress;
  logic [31:0] PipeWriteData;
  logic        LongValid;
  logic        LongReady;
  logic [4:0]  LongAddress;
  logic [31:0] LongData;
  logic        IssueValid;
  logic [4:0]  IssueAddress;
  logic [4:0]  QueryAddress1;
  logic [4:0]  QueryAddress2;
  logic        Pending1;
  logic        Pending2;
  logic        WriteEnable;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;

  exp_t pipe_q[$];
  exp_t long_q[$];
  exp_t mon_e;
  int   checks;
  int   failures;
  int   cyc;
  logic ready_q;

  wb_write_arbiter #(.DEPTH(2)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .PipeWriteEnable(PipeWriteEnable), .PipeWriteAddress(PipeWriteAddress),
    .PipeWriteData(PipeWriteData),
    .LongValid(LongValid), .LongReady(LongReady), .LongAddress(LongAddress),
    .LongData(LongData),
    .IssueValid(IssueValid), .IssueAddress(IssueAddress),
    .QueryAddress1(QueryAddress1), .QueryAddress2(QueryAddress2),
    .Pending1(Pending1), .Pending2(Pending2),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1; LongValid = 1'b1; LongAddress = 5'd4; LongData = 32'h4444_4444;
    repeat (2) @(negedge clock);
    checks++;
    if (WriteEnable !== 1'b0 || WriteAddress !== 5'd0 || WriteData !== 32'd0) begin
      failures++; $display("FAIL reset_outputs got we=%b a=%0d d=%h want 0/0/0", WriteEnable, WriteAddress, WriteData);
    end
    checks++;
    if (LongReady !== 1'b0) begin failures++; $display("FAIL reset_long_ready got %b want 0", LongReady); end
    checks++;
    if (Pending1 !== 1'b0 || Pending2 !== 1'b0) begin
      failures++; $display("FAIL reset_pending got %b%b want 00", Pending1, Pending2);
    end
    LongValid = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++;
    if (LongReady !== 1'b1) begin failures++; $display("FAIL release_long_ready got %b want 1", LongReady); end
  endtask

  task automatic test_pipe();
    @(negedge clock);
    PipeWriteEnable = 1'b1; PipeWriteAddress = 5'd5; PipeWriteData = 32'h1234_5678;
    pipe_q.push_back('{5'd5, 32'h1234_5678, cyc + 1});
    @(negedge clock);
    PipeWriteEnable = 1'b0;
    checks++;
    if (WriteEnable !== 1'b1 || WriteAddress !== 5'd5 || WriteData !== 32'h1234_5678) begin
      failures++; $display("FAIL pipe_latency got we=%b a=%0d d=%h want 1/5/12345678", WriteEnable, WriteAddress, WriteData);
    end
    @(negedge clock);
    checks++;
    if (WriteEnable !== 1'b0) begin failures++; $display("FAIL pipe_idle got we=%b want 0", WriteEnable); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      PipeWriteEnable = 1'b1; PipeWriteAddress = 5'(k + 1); PipeWriteData = $urandom;
      pipe_q.push_back('{PipeWriteAddress, PipeWriteData, cyc + 1});
    end
    @(negedge clock);
    PipeWriteEnable = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_long();
    @(negedge clock);
    LongValid = 1'b1; LongAddress = 5'd7; LongData = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (LongReady !== 1'b1) begin failures++; $display("FAIL long_ready_idle got %b want 1", LongReady); end
    long_q.push_back('{5'd7, 32'hDEAD_BEEF, 0});
    @(negedge clock);
    LongValid = 1'b0;
    checks++;
    if (WriteEnable !== 1'b0) begin failures++; $display("FAIL long_no_bypass got we=%b want 0", WriteEnable); end
    @(negedge clock);
    checks++;
    if (WriteEnable !== 1'b1 || WriteAddress !== 5'd7 || WriteData !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL long_latency got we=%b a=%0d d=%h want 1/7/deadbeef", WriteEnable, WriteAddress, WriteData);
    end
    @(negedge clock);
    checks++;
    if (WriteEnable !== 1'b0) begin failures++; $display("FAIL long_idle got we=%b want 0", WriteEnable); end
  endtask

  task automatic test_backpressure();
    logic [4:0]  la [3];
    logic [31:0] ld [3];
    int li;
    la[0] = 5'd17; la[1] = 5'd18; la[2] = 5'd19;
    ld[0] = 32'hA000_0017; ld[1] = 32'hA000_0018; ld[2] = 32'hA000_0019;
    li = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      PipeWriteEnable = 1'b1; PipeWriteAddress = 5'(10 + k); PipeWriteData = $urandom;
      pipe_q.push_back('{PipeWriteAddress, PipeWriteData, cyc + 1});
      LongValid = (li < 3);
      if (li < 3) begin LongAddress = la[li]; LongData = ld[li]; end
      #1;
      if (LongValid && LongReady) begin long_q.push_back('{la[li], ld[li], 0}); li++; end
    end
    checks++;
    if (li !== 2) begin failures++; $display("FAIL bp_accept_count got %0d want 2", li); end
    checks++;
    if (LongReady !== 1'b0) begin failures++; $display("FAIL bp_full_ready got %b want 0", LongReady); end
    @(negedge clock);
    PipeWriteEnable = 1'b0;
    #1;
    checks++;
    if (LongReady !== 1'b0) begin failures++; $display("FAIL bp_no_slot_reuse got %b want 0", LongReady); end
    if (LongValid && LongReady && li < 3) begin long_q.push_back('{la[li], ld[li], 0}); li++; end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      LongValid = (li < 3);
      if (li < 3) begin LongAddress = la[li]; LongData = ld[li]; end
      #1;
      if (LongValid && LongReady) begin long_q.push_back('{la[li], ld[li], 0}); li++; end
    end
    LongValid = 1'b0;
    checks++;
    if (li !== 3) begin failures++; $display("FAIL bp_ready_return accepted %0d want 3", li); end
    repeat (3) @(negedge clock);
    checks++;
    if (long_q.size() != 0) begin failures++; $display("FAIL bp_drain left %0d want 0", long_q.size()); end
  endtask

  task automatic test_zero();
    @(negedge clock);
    PipeWriteEnable = 1'b1; PipeWriteAddress = 5'd0; PipeWriteData = 32'hFFFF_FFFF;
    LongValid = 1'b1; LongAddress = 5'd0; LongData = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (LongReady !== 1'b1) begin failures++; $display("FAIL zero_long_ready got %b want 1", LongReady); end
    @(negedge clock);
    PipeWriteEnable = 1'b0; LongValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (WriteEnable !== 1'b0) begin failures++; $display("FAIL zero_no_write cycle %0d got we=%b want 0", k, WriteEnable); end
      @(negedge clock);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    IssueValid = 1'b1; IssueAddress = 5'd9; QueryAddress1 = 5'd9; QueryAddress2 = 5'd10;
    #1;
    checks++;
    if (Pending1 !== 1'b0) begin failures++; $display("FAIL sb_no_bypass got %b want 0", Pending1); end
    @(negedge clock);
    IssueValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (Pending1 !== PEND_ON || Pending2 !== 1'b0) begin
        failures++; $display("FAIL sb_pending got %b%b want %b0", Pending1, Pending2, PEND_ON);
      end
      @(negedge clock);
    end
    LongValid = 1'b1; LongAddress = 5'd9; LongData = 32'h9999_0009;
    long_q.push_back('{5'd9, 32'h9999_0009, 0});
    @(negedge clock);
    LongValid = 1'b0;
    checks++;
    if (Pending1 !== PEND_ON) begin failures++; $display("FAIL sb_pending_queued got %b want %b", Pending1, PEND_ON); end
    IssueValid = 1'b1; IssueAddress = 5'd3; QueryAddress2 = 5'd3;
    @(negedge clock);
    checks++;
    if (WriteEnable !== 1'b1 || WriteAddress !== 5'd9 || Pending1 !== 1'b0) begin
      failures++; $display("FAIL sb_clear got we=%b a=%0d p1=%b want 1/9/0", WriteEnable, WriteAddress, Pending1);
    end
    IssueValid = 1'b0; LongValid = 1'b1; LongAddress = 5'd3; LongData = 32'h3333_0003;
    long_q.push_back('{5'd3, 32'h3333_0003, 0});
    @(negedge clock);
    LongValid = 1'b0; IssueValid = 1'b1; IssueAddress = 5'd3;
    @(negedge clock);
    IssueValid = 1'b0;
    checks++;
    if (WriteEnable !== 1'b1 || WriteAddress !== 5'd3 || Pending2 !== PEND_ON) begin
      failures++; $display("FAIL sb_set_wins got we=%b a=%0d p2=%b want 1/3/%b", WriteEnable, WriteAddress, Pending2, PEND_ON);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_stall();
    @(negedge clock);
    PipeWriteEnable = 1'b1; PipeWriteAddress = 5'd20; PipeWriteData = 32'hCAFE_0020;
    pipe_q.push_back('{5'd20, 32'hCAFE_0020, cyc + 1});
    LongValid = 1'b1; LongAddress = 5'd21; LongData = 32'hBEEF_0021;
    @(negedge clock);
    PipeWriteAddress = 5'd22; PipeWriteData = 32'hCAFE_0022;
    pipe_q.push_back('{5'd22, 32'hCAFE_0022, cyc + 1});
    LongAddress = 5'd23; LongData = 32'hBEEF_0023;
    @(negedge clock);
    PipeWriteAddress = 5'd24; PipeWriteData = 32'hCAFE_0024;
    pipe_q.push_back('{5'd24, 32'hCAFE_0024, cyc + 1});
    LongValid = 1'b0;
    @(negedge clock);
    PipeWriteEnable = 1'b0; ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (LongReady !== 1'b0) begin failures++; $display("FAIL stall_long_ready got %b want 0", LongReady); end
      @(negedge clock);
      checks++;
      if (WriteEnable !== 1'b1 || WriteAddress !== 5'd24 || WriteData !== 32'hCAFE_0024) begin
        failures++; $display("FAIL stall_hold got we=%b a=%0d d=%h want 1/24/cafe0024", WriteEnable, WriteAddress, WriteData);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (WriteEnable !== 1'b0 || WriteAddress !== 5'd0 || WriteData !== 32'd0) begin
      failures++; $display("FAIL reset_async got we=%b a=%0d d=%h want 0/0/0", WriteEnable, WriteAddress, WriteData);
    end
    @(negedge clock);
    reset = 1'b0; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (WriteEnable !== 1'b0) begin failures++; $display("FAIL reset_drop cycle %0d got we=%b a=%0d want 0", k, WriteEnable, WriteAddress); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; ready_q = 1'b0;
    reset = 1'b1; ready = 1'b1;
    PipeWriteEnable = 1'b0; PipeWriteAddress = 5'd0; PipeWriteData = 32'd0;
    LongValid = 1'b0; LongAddress = 5'd0; LongData = 32'd0;
    IssueValid = 1'b0; IssueAddress = 5'd0; QueryAddress1 = 5'd0; QueryAddress2 = 5'd0;
    fork
      forever begin
        @(posedge clock);
        cyc = cyc + 1;
        ready_q = ready;
      end
      forever begin
        @(negedge clock);
        if (!reset && ready_q) begin
          if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
            mon_e = pipe_q.pop_front();
            checks++;
            if (WriteEnable !== 1'b1 || WriteAddress !== mon_e.address || WriteData !== mon_e.data) begin
              failures++;
              $display("FAIL sb_pipe_write cyc=%0d got we=%b a=%0d d=%h want a=%0d d=%h",
                       cyc, WriteEnable, WriteAddress, WriteData, mon_e.address, mon_e.data);
            end
          end else if (WriteEnable === 1'b1) begin
            checks++;
            if (long_q.size() == 0) begin
              failures++;
              $display("FAIL sb_unexpected_write cyc=%0d got a=%0d d=%h want none", cyc, WriteAddress, WriteData);
            end else begin
              mon_e = long_q.pop_front();
              if (WriteAddress !== mon_e.address || WriteData !== mon_e.data) begin
                failures++;
                $display("FAIL sb_long_write cyc=%0d got a=%0d d=%h want a=%0d d=%h",
                         cyc, WriteAddress, WriteData, mon_e.address, mon_e.data);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_pipe();
    test_back_to_back();
    test_long();
    test_backpressure();
    test_zero();
    test_scoreboard();
    test_reset_stall();

    checks++;
    if (pipe_q.size() != 0 || long_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got pipe=%0d long=%0d want 0/0", pipe_q.size(), long_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
